// File: rtl/telegraph_pkg.sv
// Shared types and constants for the telegraph receiver.
// Optional parity stage is enabled by defining TELEGRAPH_PARITY_EN.
package telegraph_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  localparam int   DATA_W_DEF = 8;
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;

endpackage

// File: rtl/telegraph_shift.sv
// LSB-first payload shift register with bit counter.
// last_o flags that the next shift completes the payload.
module telegraph_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] sr_q;
  logic [CW-1:0]     cnt_q;

  assign last_o = (cnt_q == CW'(DATA_W - 1));
  assign data_o = sr_q;

  // Clear on start bit; shift in from the top so bit 0 lands at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {bit_i, sr_q[DATA_W-1:1]};
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/telegraph_rx.sv
// Telegraph frame receiver: start(1), payload LSB-first, opt parity, stop(0).
// Parity stage present only when TELEGRAPH_PARITY_EN is defined.
module telegraph_rx
  import telegraph_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ClkEn,
  input  logic              DataIn,
  output logic [DATA_W-1:0] Data,
  output logic              Valid,
  input  logic              Ready,
  output logic              ParityErr,
  output logic              FrameErr,
  output logic              Overrun,
  output logic              Busy
);

  state_e            state_q, state_d;
  logic              clr, shift, done, ferr;
  logic              last;
  logic [DATA_W-1:0] sh_data;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, perr_q, ferr_q, ovr_q;
  logic              perr_d;

  telegraph_shift #(.DATA_W(DATA_W)) u_shift (
    .clk     (Clk),
    .rst_n   (Rst),
    .clr_i   (clr),
    .shift_i (shift),
    .bit_i   (DataIn),
    .data_o  (sh_data),
    .last_o  (last)
  );

  // Next-state and strobe decode; nothing moves without ClkEn.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    ferr    = 1'b0;
    if (ClkEn) begin
      unique case (state_q)
        S_IDLE: begin
          if (DataIn == START_BIT) begin
            state_d = S_DATA;
            clr     = 1'b1;
          end
        end
        S_DATA: begin
          shift = 1'b1;
          if (last) begin
`ifdef TELEGRAPH_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          state_d = S_IDLE;
          if (DataIn == STOP_BIT) done = 1'b1;
          else                    ferr = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef TELEGRAPH_PARITY_EN
  logic par_q;

  // Capture the received parity bit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      par_q <= 1'b0;
    else if (ClkEn && state_q == S_PARITY)
      par_q <= DataIn;
  end

  assign perr_d = ((^sh_data) ^ par_q) != PARITY_ODD;
`else
  assign perr_d = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Output holding register with valid/ready and overrun handling.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr;
      ovr_q  <= done && valid_q && !Ready;
      if (done && (!valid_q || Ready)) begin
        data_q  <= sh_data;
        perr_q  <= perr_d;
        valid_q <= 1'b1;
      end else if (valid_q && Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Data      = data_q;
  assign Valid     = valid_q;
  assign ParityErr = perr_q;
  assign FrameErr  = ferr_q;
  assign Overrun   = ovr_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_telegraph_rx.sv
// Self-checking bench for telegraph_rx (DATA_W=8, even parity).
// Follows TELEGRAPH_PARITY_EN to decide whether a parity bit is sent.
module tb_telegraph_rx;

`ifdef TELEGRAPH_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       ClkEn = 1'b0;
  logic       DataIn = 1'b0;
  logic       Ready = 1'b1;
  logic [7:0] Data;
  logic       Valid, ParityErr, FrameErr, Overrun, Busy;

  int n_chk  = 0;
  int n_fail = 0;

  telegraph_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ClkEn     (ClkEn),
    .DataIn    (DataIn),
    .Data      (Data),
    .Valid     (Valid),
    .Ready     (Ready),
    .ParityErr (ParityErr),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] pay;
    logic       par;
    logic       stp;
    int         gap;
    logic       exp_v;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One ClkEn strobe carrying bit b, then gap idle cycles.
  task automatic strobe(input logic b, input int gap);
    ClkEn  = 1'b1;
    DataIn = b;
    @(negedge Clk);
    ClkEn  = 1'b0;
    DataIn = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  // Start, payload LSB-first, and parity if built in; no stop bit.
  task automatic send_body(input logic [7:0] pay, input logic par,
                           input int gap);
    logic [7:0] p;
    p = pay;
    strobe(1'b1, gap);
    for (int i = 0; i < 8; i++) strobe(p[i], gap);
    if (PEN) strobe(par, gap);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h5A, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0};

    #1;
    check("rst_valid", Valid, 0);
    check("rst_data", Data, 0);
    check("rst_busy", Busy, 0);
    check("rst_ferr", FrameErr, 0);
    check("rst_ovr", Overrun, 0);
    check("rst_perr", ParityErr, 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    strobe(1'b0, 0);
    check("idle_zero_busy", Busy, 0);

    Ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_body(tbl[k].pay, tbl[k].par, tbl[k].gap);
      check("pre_stop_busy", Busy, 1);
      strobe(tbl[k].stp, 0);
      check($sformatf("v%0d_valid", k), Valid, tbl[k].exp_v);
      if (tbl[k].exp_v) begin
        check($sformatf("v%0d_data", k), Data, tbl[k].pay);
        check($sformatf("v%0d_perr", k), ParityErr,
              tbl[k].exp_pe & PEN);
      end
      check($sformatf("v%0d_ferr", k), FrameErr, tbl[k].exp_fe);
      check($sformatf("v%0d_busy", k), Busy, 0);
      @(negedge Clk);
      check($sformatf("v%0d_valid_clr", k), Valid, 0);
      check($sformatf("v%0d_ferr_clr", k), FrameErr, 0);
    end

    Ready = 1'b0;
    send_body(8'h3C, 1'b0, 0);
    strobe(1'b0, 0);
    check("ovr_first_valid", Valid, 1);
    check("ovr_first_data", Data, 8'h3C);
    check("ovr_no_pulse_yet", Overrun, 0);
    send_body(8'h81, 1'b0, 0);
    strobe(1'b0, 0);
    check("ovr_pulse", Overrun, 1);
    check("ovr_data_kept", Data, 8'h3C);
    check("ovr_valid_kept", Valid, 1);
    @(negedge Clk);
    check("ovr_pulse_end", Overrun, 0);
    Ready = 1'b1;
    @(negedge Clk);
    check("ovr_valid_clr", Valid, 0);

    Ready = 1'b0;
    send_body(8'h11, 1'b0, 0);
    strobe(1'b0, 0);
    check("coin_first_data", Data, 8'h11);
    send_body(8'h22, 1'b0, 0);
    Ready = 1'b1;
    strobe(1'b0, 0);
    check("coin_valid", Valid, 1);
    check("coin_data", Data, 8'h22);
    check("coin_no_ovr", Overrun, 0);
    @(negedge Clk);
    check("coin_valid_clr", Valid, 0);

    strobe(1'b1, 0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    check("mid_busy", Busy, 1);
    #2 Rst = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_data", Data, 0);
    check("mid_rst_valid", Valid, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    strobe(1'b0, 0);
    check("post_rst_idle", Busy, 0);
    send_body(8'h5A, 1'b0, 0);
    strobe(1'b0, 0);
    check("post_rst_valid", Valid, 1);
    check("post_rst_data", Data, 8'h5A);
    check("post_rst_perr", ParityErr, 0);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/telegraph_rx.md
TELEGRAPH_RX -- requirements
Module: telegraph_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving payload bits per frame (legal 4..16).
REQ-002 The block SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL have port Clk, input, width 1: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Rst, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port ClkEn, input, width 1: one-cycle bit strobe from OnePulser; one strobe = one telegraph bit.
REQ-006 The block SHALL have port DataIn, input, width 1: key/switch level, sampled only on a ClkEn cycle.
REQ-007 The block SHALL have port Data, output, width DATA_W: received payload, LSB received first.
REQ-008 The block SHALL have port Valid, output, width 1: Data holds an unconsumed frame.
REQ-009 The block SHALL have port Ready, input, width 1: consumer accepts Data on a Valid&&Ready cycle.
REQ-010 The block SHALL have port ParityErr, output, width 1: qualifies Data; valid while Valid=1.
REQ-011 The block SHALL have port FrameErr, output, width 1: one-cycle pulse on a bad stop bit.
REQ-012 The block SHALL have port Overrun, output, width 1: one-cycle pulse when a completed frame is dropped.
REQ-013 The block SHALL have port Busy, output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP; it advances only on ClkEn=1 cycles and holds otherwise.
REQ-015 In IDLE, ClkEn with DataIn=1 (start bit) SHALL go to DATA with the bit counter cleared; ClkEn with DataIn=0 SHALL stay in IDLE.
REQ-016 In DATA, each ClkEn SHALL shift DataIn into the shift register LSB-first and increment the counter; after the DATA_W-th bit it SHALL go to PARITY (macro defined) or STOP (macro undefined).
REQ-017 In PARITY, ClkEn SHALL capture DataIn as the parity bit and go to STOP.
REQ-018 In STOP, ClkEn with DataIn=0 SHALL complete the frame; ClkEn with DataIn=1 SHALL pulse FrameErr for exactly 1 cycle, discard the frame, and return to IDLE.
REQ-019 On completion, Data/ParityErr/Valid SHALL update on the clock edge at which the stop-bit ClkEn is sampled, so Valid is high in the cycle immediately after that ClkEn cycle; the FSM SHALL return to IDLE.
REQ-020 ParityErr SHALL be 1 when XOR(payload, parity bit) differs from PARITY_ODD.
REQ-021 Valid SHALL remain high and Data stable until a Valid&&Ready cycle, which SHALL clear Valid on the next edge.
REQ-022 If a frame completes while Valid=1 and Ready=0, the new frame SHALL be dropped, the held Data kept, and Overrun SHALL pulse for exactly 1 cycle.
REQ-023 If completion and Valid&&Ready coincide in the same cycle, the new frame SHALL be loaded, Valid SHALL stay 1, and there SHALL be no Overrun.
REQ-024 The receive FSM SHALL run independently of Valid/Ready; a back-pressured consumer SHALL never stall bit reception.

Reset
REQ-025 Asserting Rst=0 SHALL immediately force IDLE, counter=0, shift register=0, Data=0, Valid=0, ParityErr=0, FrameErr=0, Overrun=0, Busy=0, including mid-frame.
REQ-026 After Rst deasserts, the first ClkEn SHALL be treated as an IDLE sample.

Configuration
REQ-027 With macro TELEGRAPH_PARITY_EN defined, the PARITY state and parity check SHALL be present.
REQ-028 With TELEGRAPH_PARITY_EN undefined, PARITY SHALL be absent, DATA SHALL go directly to STOP, and ParityErr SHALL be tied to 0.

Structure
REQ-029 Package telegraph_pkg SHALL hold the FSM state enum, default DATA_W, and the start/stop bit level constants.
REQ-030 Sub-module telegraph_shift SHALL implement the DATA_W shift register with bit counter and last-bit flag; the FSM and output register SHALL be in telegraph_rx.

Verification
REQ-031 Macro on, DATA_W=8, even parity: bits 1, 0xA5 LSB-first, parity 0, stop 0, Ready=1 -> Valid for 1 cycle with Data=0xA5, ParityErr=0.
REQ-032 Same frame with parity bit 1 -> Data=0xA5, ParityErr=1.
REQ-033 Stop bit driven as 1 -> FrameErr pulses 1 cycle, Valid stays 0, Busy=0 afterwards.
REQ-034 Ready=0; send 0x3C, then 0x81 -> Data stays 0x3C, Overrun pulses once; Ready=1 then clears Valid.
REQ-035 Rst=0 after 4 data bits, then full frame 0x5A -> no output from the partial frame; Data=0x5A delivered.
REQ-036 Macro off: frame with no parity bit, 0xFF -> Valid with Data=0xFF, ParityErr=0.
